// File: rtl/seg7_scan4.sv
// Four-digit multiplexed 7-segment driver (active-low common anode) with frame-synchronous
// digit capture, per-digit blink and a colon dot. Define SEG7_SCAN4_DIM_PWM_EN for anode PWM dimming.
module seg7_scan4 #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] blink_mask,
  input  logic       colon_en,
`ifdef SEG7_SCAN4_DIM_PWM_EN
  input  logic [2:0] bright,
`endif
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0]   prescaler;
  logic [1:0]      idx;
  logic [3:0][3:0] shadow;
  logic [BW-1:0]   blink_cnt;
  logic            blink_on;
  logic            tick;
  logic            pwm_on;
  logic [3:0]      an_d;
  logic [6:0]      seg_d;
  logic            dp_d;

  assign tick = (prescaler == PS_LAST);

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Shadow loads only at the end of the last slot so a whole frame shows one snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      idx        <= 2'd0;
      shadow     <= '0;
      frame_done <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      frame_done <= tick && (idx == 2'd3);
      if (tick) idx <= idx + 2'd1;
      if (tick && (idx == 2'd3)) shadow <= {in3, in2, in1, in0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

`ifdef SEG7_SCAN4_DIM_PWM_EN
  // SCAN_DIV is a multiple of 8, so prescaler*8 < (bright+1)*SCAN_DIV reduces to this.
  logic [31:0] on_lim;
  assign on_lim = (32'(bright) + 32'd1) * 32'(SCAN_DIV / 8);
  assign pwm_on = (32'(prescaler) < on_lim);
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    an_d  = pwm_on ? ~(4'b0001 << idx) : 4'b1111;
    seg_d = (blink_mask[idx] && !blink_on) ? 7'h7F : decode(shadow[idx]);
    dp_d  = !((idx == 2'd2) && colon_en && blink_on);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
